// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out receiver.
package sipo_pkg;

  // Receiver framing state: waiting for a sync-qualified first bit, or
  // collecting the remaining bits of a frame.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage : sipo_pkg

// File: rtl/sipo_rx_if.sv
// Serial input strobe/data plus the parallel output handshake of sipo_rx.
interface sipo_rx_if import sipo_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             serial_in;
  logic             shift_en;
  logic             sync;
  logic             out_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] parallel_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;

  // Producer of serial bits and consumer of parallel words.
  modport master (
    output serial_in, shift_en, sync, out_ready, clr_ovr,
    input  parallel_out, out_valid, busy, overrun
  );

  // The receiver itself.
  modport slave (
    input  serial_in, shift_en, sync, out_ready, clr_ovr,
    output parallel_out, out_valid, busy, overrun
  );

endinterface : sipo_rx_if

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter: assembles one MSB-first frame and flags
// the sample that completes it. A non-zero count means a frame is open.
module sipo_shift_core import sipo_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             sync,
  input  logic             serial_in,
  output logic [WIDTH-1:0] word,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             last_bit;

  // The open frame already holds WIDTH-1 bits, so the next plain bit ends it.
  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));
  // A sync always restarts, so it can never be the completing bit.
  assign done     = shift_en & ~sync & last_bit;
  // Stable from the completing edge until the next accepted bit.
  assign word     = shift_q;

  // Sync restarts the frame; plain bits shift in only while a frame is open.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      if (sync) begin
        shift_q   <= {{(WIDTH-1){1'b0}}, serial_in};
        bit_cnt_q <= CNT_W'(1);
      end else if (bit_cnt_q != '0) begin
        shift_q   <= {shift_q[WIDTH-2:0], serial_in};
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule : sipo_shift_core

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: framing FSM, output word register with a
// valid/ready handshake, and a sticky overrun flag for dropped words.
module sipo_rx import sipo_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic      clk,
  input logic      rst,
  sipo_rx_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] core_word;
  logic             core_done;
  logic             pend_q;
  logic [WIDTH-1:0] out_q;
  logic             valid_q;
  logic             ovr_q;
  logic             take;
  logic             ovr_set;

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (bus.shift_en),
    .sync      (bus.sync),
    .serial_in (bus.serial_in),
    .word      (core_word),
    .done      (core_done)
  );

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: open on a sync-qualified bit, close on the completing bit.
  // NOTE: state_d takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.shift_en && bus.sync) state_d = SHIFT;
      SHIFT:   if (core_done)                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A finished word lands one edge after completion; it is taken only if the
  // register is empty or being consumed on that same edge.
  assign take    = pend_q & (~valid_q | bus.out_ready);
  assign ovr_set = pend_q & valid_q & ~bus.out_ready;

  // Output register, handshake and sticky overrun (setting beats clearing).
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= 1'b0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q <= core_done;
      if (take) begin
        out_q   <= core_word;
        valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (ovr_set)          ovr_q <= 1'b1;
      else if (bus.clr_ovr) ovr_q <= 1'b0;
    end
  end

  assign bus.parallel_out = out_q;
  assign bus.out_valid    = valid_q;
  assign bus.busy         = (state_q == SHIFT);
  assign bus.overrun      = ovr_q;

endmodule : sipo_rx
